// File: rtl/cnn_result_packer.sv
// Collects the un-stallable CNN result stream into a FIFO and replays it as a
// sign-extended AXI4-Stream with per-frame tlast, overflow and length checks.
module cnn_result_packer #(
    parameter int DATA_WIDTH = 20,
    parameter int OUT_WIDTH  = 32,
    parameter int FIFO_DEPTH = 64,
    parameter int FRAME_LEN  = 3600
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    input  logic                          in_done,
    output logic [OUT_WIDTH-1:0]          m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          frame_done,
    output logic                          overflow,
    output logic                          length_err,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_CLOSED = 2'd1,
        S_ERROR  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count;
    logic [CW-1:0]         frame_cnt;
    logic [DATA_WIDTH:0]   head;
    logic                  full, pop, push, drop, frame_end, last_pop, early_done;

    assign head       = mem[rd_ptr];
    assign full       = (count == (AW+1)'(FIFO_DEPTH));
    assign pop        = m_axis_tvalid && m_axis_tready;
    assign push       = in_valid && (state == S_RUN) && (!full || pop);
    assign drop       = in_valid && (state == S_RUN) && full && !pop;
    assign frame_end  = push && (frame_cnt == CW'(FRAME_LEN - 1));
    assign last_pop   = pop && head[DATA_WIDTH];
    assign early_done = in_done && (state == S_RUN) && !frame_end;

    // ERROR always holds count at 0, so tvalid needs no state term.
    assign m_axis_tvalid = (count != '0);
    assign m_axis_tlast  = m_axis_tvalid && head[DATA_WIDTH];
    assign fill_level    = count;

    generate
        if (OUT_WIDTH > DATA_WIDTH) begin : g_sext
            assign m_axis_tdata = m_axis_tvalid ?
                {{(OUT_WIDTH-DATA_WIDTH){head[DATA_WIDTH-1]}}, head[DATA_WIDTH-1:0]} : '0;
        end else begin : g_same
            assign m_axis_tdata = m_axis_tvalid ? head[DATA_WIDTH-1:0] : '0;
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN: begin
                if (drop)
                    state_nxt = S_ERROR;
                else if (frame_end)
                    state_nxt = S_CLOSED;
            end
            S_CLOSED: begin
                if (last_pop)
                    state_nxt = S_RUN;
            end
            S_ERROR:  state_nxt = S_ERROR;
            default:  state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_RUN;
        else if (clear)
            state <= S_RUN;
        else
            state <= state_nxt;
    end

    // Storage carries no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {frame_end, in_data};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear || drop || state == S_ERROR) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A done in RUN without the closing push restarts the frame count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            frame_cnt <= '0;
        else if (clear)
            frame_cnt <= '0;
        else if (early_done)
            frame_cnt <= '0;
        else if (push)
            frame_cnt <= frame_end ? '0 : frame_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow   <= 1'b0;
            length_err <= 1'b0;
            frame_done <= 1'b0;
        end else if (clear) begin
            overflow   <= 1'b0;
            length_err <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            overflow   <= overflow | drop;
            length_err <= length_err | early_done;
            frame_done <= (state == S_CLOSED) && last_pop;
        end
    end

endmodule

// File: tb/tb_cnn_result_packer.sv
// Bench for cnn_result_packer: directed scenarios plus random traffic, all
// checked every cycle against a queue-based model of the packer.
module tb_cnn_result_packer;

    localparam int DW = 20;
    localparam int OW = 32;
    localparam int D  = 4;
    localparam int FL = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_done = 1'b0;
    logic [OW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          m_axis_tlast;
    logic          frame_done;
    logic          overflow;
    logic          length_err;
    logic [$clog2(D):0] fill_level;

    cnn_result_packer #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .FIFO_DEPTH(D), .FRAME_LEN(FL)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_data(in_data), .in_valid(in_valid), .in_done(in_done),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .frame_done(frame_done), .overflow(overflow),
        .length_err(length_err), .fill_level(fill_level)
    );

    always #5 clk = ~clk;

    // Model: the FIFO contents as a queue, frame position and a 3-way mode.
    typedef struct packed { logic last; logic [DW-1:0] d; } ent_t;
    localparam int RUN = 0, CLOSED = 1, ERR = 2;
    ent_t q[$];
    int   m_cnt, m_st;
    bit   m_ovf, m_lerr, m_fd;
    int   n_vec = 0, n_err = 0;

    function automatic logic [OW-1:0] sext(logic [DW-1:0] d);
        logic signed [DW-1:0] s;
        logic signed [OW-1:0] r;
        s = d;
        r = s;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_cnt = 0; m_st = RUN; m_ovf = 0; m_lerr = 0; m_fd = 0;
    endtask

    task automatic compare();
        chk("tvalid", 32'(m_axis_tvalid), 32'(q.size() > 0));
        chk("fill_level", 32'(fill_level), q.size());
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("length_err", 32'(length_err), 32'(m_lerr));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        if (q.size() > 0) begin
            chk("tdata", m_axis_tdata, sext(q[0].d));
            chk("tlast", 32'(m_axis_tlast), 32'(q[0].last));
        end
    endtask

    task automatic model_update();
        bit pop, lastpop, push, drop, fin;
        int st0;
        st0     = m_st;
        pop     = (q.size() > 0) && m_axis_tready;
        lastpop = pop && q[0].last;
        push    = in_valid && st0 == RUN && (q.size() < D || pop);
        drop    = in_valid && st0 == RUN && q.size() == D && !pop;
        fin     = push && m_cnt == FL - 1;
        m_fd    = (st0 == CLOSED) && lastpop;
        if (pop) void'(q.pop_front());
        if (push) begin
            q.push_back({fin, in_data});
            m_cnt = fin ? 0 : m_cnt + 1;
            if (fin) m_st = CLOSED;
        end
        if (in_done && st0 == RUN && !fin) begin
            m_lerr = 1; m_cnt = 0;
        end
        if (drop) begin
            m_ovf = 1; m_st = ERR; q.delete();
        end
        if (st0 == CLOSED && lastpop) m_st = RUN;
        if (clear) model_reset();
    endtask

    // Called at a negedge: apply inputs, then check outputs against the model.
    task automatic drive(bit v, logic [DW-1:0] d, bit done, bit rdy, bit clr = 0);
        in_valid = v; in_data = d; in_done = done; m_axis_tready = rdy; clear = clr;
        #1 compare();
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(bit v, logic [DW-1:0] d, bit done, bit rdy, bit clr = 0);
        drive(v, d, done, rdy, clr);
        tick();
    endtask

    task automatic sext_frame();
        logic [DW-1:0] vals [FL];
        logic [OW-1:0] exps [FL];
        vals = '{20'h00005, 20'hFFFFF, 20'h7FFFF, 20'h80000, 20'h12345, 20'hABCDE};
        exps = '{32'h00000005, 32'hFFFFFFFF, 32'h0007FFFF, 32'hFFF80000, 32'h00012345, 32'hFFFABCDE};
        for (int i = 0; i < FL; i++) begin
            drive(1, vals[i], 0, 1);
            if (i > 0) begin
                chk("sext_tdata", m_axis_tdata, exps[i-1]);
                chk("sext_tlast", 32'(m_axis_tlast), 0);
            end
            tick();
        end
        drive(0, 0, 0, 1);
        chk("sext_tdata_last", m_axis_tdata, exps[FL-1]);
        chk("sext_tlast_last", 32'(m_axis_tlast), 1);
        tick();
        drive(0, 0, 0, 1);
        chk("sext_frame_done", 32'(frame_done), 1);
        chk("sext_tvalid_after", 32'(m_axis_tvalid), 0);
        tick();
        drive(0, 0, 0, 1);
        chk("sext_frame_done_pulse", 32'(frame_done), 0);
        tick();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_tvalid", 32'(m_axis_tvalid), 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_fill", 32'(fill_level), 0);
        chk("rst_flags", {29'd0, overflow, length_err, frame_done}, 0);
        @(negedge clk);
        reset = 1'b0;

        sext_frame();

        // Backpressure: four buffered, head held, then in-order drain.
        for (int i = 0; i < 4; i++) step(1, 20'h100 + 20'(i), 0, 0);
        drive(0, 0, 0, 0);
        chk("bp_fill", 32'(fill_level), 4);
        chk("bp_tdata_held", m_axis_tdata, 32'h100);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 1);
            chk("bp_order", m_axis_tdata, 32'h100 + i);
            tick();
        end
        drive(0, 0, 0, 1);
        chk("bp_fill_empty", 32'(fill_level), 0);
        chk("bp_no_ovf", 32'(overflow), 0);
        tick();
        for (int i = 0; i < 2; i++) step(1, 20'h104 + 20'(i), 0, 1);
        repeat (3) step(0, 0, 0, 1);

        // Full with simultaneous push and pop.
        for (int i = 0; i < 4; i++) step(1, 20'h200 + 20'(i), 0, 0);
        for (int i = 0; i < 2; i++) begin
            drive(1, 20'h204 + 20'(i), 0, 1);
            chk("full_pp_fill", 32'(fill_level), 4);
            chk("full_pp_order", m_axis_tdata, 32'h200 + i);
            tick();
        end
        drive(0, 0, 0, 1);
        chk("full_pp_fill_after", 32'(fill_level), 4);
        chk("full_pp_no_ovf", 32'(overflow), 0);
        tick();
        repeat (6) step(0, 0, 0, 1);

        // Overflow, then clear and a fresh frame under random ready.
        for (int i = 0; i < 5; i++) step(1, 20'h300 + 20'(i), 0, 0);
        drive(0, 0, 0, 0);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_tvalid", 32'(m_axis_tvalid), 0);
        tick();
        step(1, 20'h3FF, 0, 1);
        drive(0, 0, 0, 1);
        chk("ovf_held_error", 32'(m_axis_tvalid), 0);
        tick();
        step(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0);
        chk("ovf_cleared", 32'(overflow), 0);
        tick();
        for (int i = 0; i < FL; i++) step(1, 20'($urandom), 0, 1'($urandom));
        repeat (8) step(0, 0, 0, 1);

        // Early done.
        for (int i = 0; i < 2; i++) step(1, 20'h400 + 20'(i), 0, 0);
        step(0, 0, 1, 0);
        drive(0, 0, 0, 0);
        chk("early_lerr", 32'(length_err), 1);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 1);
            chk("early_no_tlast", 32'(m_axis_tlast), 0);
            tick();
        end
        for (int i = 0; i < FL; i++) step(1, 20'h500 + 20'(i), 0, 1);
        repeat (3) step(0, 0, 0, 1);

        // Random traffic in segments of different ready pressure.
        for (int seg = 0; seg < 6; seg++) begin
            for (int c = 0; c < 500; c++) begin
                bit v, dn, rdy, clr;
                v   = ($urandom % 4) != 0;
                dn  = ($urandom % 40) == 0;
                rdy = ($urandom % 8) < (seg + 2);
                clr = ($urandom % 120) == 0;
                step(v, 20'($urandom), dn, rdy, clr);
            end
        end
        step(0, 0, 0, 0, 1);

        // Async reset with three entries buffered.
        for (int i = 0; i < 3; i++) step(1, 20'h600 + 20'(i), 0, 0);
        drive(0, 0, 0, 0);
        chk("pre_rst_fill", 32'(fill_level), 3);
        #2 reset = 1'b1;
        #1;
        chk("arst_tvalid", 32'(m_axis_tvalid), 0);
        chk("arst_fill", 32'(fill_level), 0);
        chk("arst_ovf", 32'(overflow), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        sext_frame();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
